sample_acc_relu: RTL and testbench
==================================

Name: sample_acc_relu

Overview:
- Downstream consumer of the layer multiplier: collects N_TERMS signed 13-bit products of one neuron's dot product and adds a bias.
- Rescales the sum by an arithmetic right shift, applies ReLU and saturates to an unsigned 8-bit activation.
- The activation has the same width and signedness as the multiplier's unsigned 8-bit operand, so it feeds the next layer directly.
- Uses ap-style block control (start/idle/done) and valid/ready streams on input and output.

Parameters:
- PROD_W, 13, width of the signed product input.
- BIAS_W, 13, width of the signed bias.
- ACC_W, 24, accumulator width. Must be ≥ max(PROD_W,BIAS_W)+clog2(N_TERMS+1)+1.
- N_TERMS, 16, number of products per dot product. Minimum 1.
- SHIFT, 4, arithmetic right shift applied before ReLU (fixed-point rescale, floor rounding).
- OUT_W, 8, unsigned activation width.

Ports:
- ap_clk  in  1  sole clock; all state updates on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  begin one dot product; sampled only in IDLE.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse on the cycle the result is accepted.
- bias  in  BIAS_W  signed bias; sampled on the start cycle.
- prod_tdata  in  PROD_W  signed product from the multiplier.
- prod_tvalid  in  1  product valid.
- prod_tready  out  1  product accepted when tvalid&tready.
- res_tdata  out  OUT_W  unsigned activation.
- res_tvalid  out  1  result valid.
- res_tready  in  1  downstream ready.

Behaviour:
- Reset values: prod_tready=0, res_tvalid=0, res_tdata=0, ap_idle=1, ap_done=0, acc=0, cnt=0, state=IDLE.
- ap_rst asserted in any state, including mid-accumulation or while a result is pending, forces these values on the next edge. Partial sums and pending results are discarded.

FSM states:
- IDLE: ap_idle=1, prod_tready=0. On ap_start: acc <= sign-extend(bias), cnt <= 0, go to ACC. ap_start asserted in any other state is ignored.
- ACC: prod_tready=1 (registered).
  - On each handshake: acc <= acc + sign-extend(prod_tdata), cnt <= cnt+1.
  - Cycles with tvalid=0 leave acc and cnt unchanged; there is no timeout.
  - On the handshake where cnt==N_TERMS-1, go to ACT; prod_tready drops to 0 on the following cycle.
- ACT: single cycle, computes the activation:
  - s = acc >>> SHIFT (arithmetic shift, floor).
  - If s < 0, result = 0.
  - Else if s > 2^OUT_W-1, result = 2^OUT_W-1.
  - Else result = s[OUT_W-1:0].
  - Register the result into res_tdata; go to OUT.
- OUT: res_tvalid=1.
  - res_tdata stays stable until accepted.
  - On res_tready: ap_done=1 for that one cycle, res_tvalid drops on the next edge, go to IDLE.
  - res_tdata keeps its last value afterwards.

Timing:
- Latency from the last product handshake to res_tvalid: 2 cycles.
- Minimum period per dot product: N_TERMS+3 cycles (IDLE, N_TERMS×ACC, ACT, OUT with immediate ready).
- With ap_start held high, transactions run back-to-back with exactly one IDLE cycle between them.

Arithmetic:
- All adds are two's complement at ACC_W. Overflow wraps and is not flagged, so the ACC_W rule must hold.

Decomposition:
- Shared package sample_acc_pkg holds:
  - state enum {IDLE, ACC, ACT, OUT};
  - default width constants PROD_W, BIAS_W, OUT_W;
  - a localparam function computing the minimum ACC_W, with an elaboration-time check.
- One combinational sub-module, sample_acc_relu_sat (acc in, OUT_W out: shift/ReLU/saturate), instantiated by the FSM and unit-tested standalone.

Test Plan:
- N_TERMS=4, SHIFT=4, bias=0, products 16, 32, -8, 40 → acc=80, res_tdata=5; res_tvalid 2 cycles after the 4th handshake; ap_done pulses once.
- bias=-100, products 10, 10, 10, 10 → acc=-60, s=-4 → res_tdata=0 (ReLU).
- bias=4095, products 4095 ×4 → acc=20475, s=1279 → res_tdata=255 (saturation).
- Input gaps: prod_tvalid low for 3 cycles between products, then res_tready low for 5 cycles.
  - acc counts only handshakes; result identical to test 1.
  - res_tdata=5 and res_tvalid stay stable throughout the stall.
  - ap_done is high only on the accept cycle.
- Reset after 2 products in ACC → next cycle prod_tready=0, ap_idle=1, res_tvalid=0. A fresh run with test-1 stimulus yields 5, with no leftover partial sum.
- ap_start held high, 3 back-to-back runs (tests 1-3) → results 5, 0, 255 in order, one IDLE cycle between runs. ap_start pulses during ACC/OUT have no effect.

Source files
------------

// File: rtl/sample_acc_pkg.sv
// Shared definitions for the sample accumulate / ReLU block.
//   state_t      : FSM states of the dot-product controller.
//   PROD_W, BIAS_W, OUT_W : default widths matching the layer multiplier.
//   min_acc_w()  : smallest accumulator width that cannot overflow for a
//                  given product width, bias width and term count.
package sample_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      ACT  = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam int PROD_W = 13;
   localparam int BIAS_W = 13;
   localparam int OUT_W  = 8;

   // N_TERMS products plus one bias, each up to max(PROD_W,BIAS_W) bits
   // signed, need clog2(N_TERMS+1) growth bits plus one bit of headroom.
   function automatic int min_acc_w(input int prod_w, input int bias_w,
                                    input int n_terms);
      int wide;
      wide = (prod_w > bias_w) ? prod_w : bias_w;
      return wide + $clog2(n_terms + 1) + 1;
   endfunction

endpackage

// File: rtl/sample_acc_relu_sat.sv
// Combinational activation stage: arithmetic right shift (floor), ReLU and
// unsigned saturation of the accumulator to an OUT_W-bit activation.
//   acc : accumulator value, two's complement, ACC_W bits
//   act : unsigned activation, OUT_W bits
module sample_acc_relu_sat #(
   parameter int ACC_W = 24,
   parameter int SHIFT = 4,
   parameter int OUT_W = 8
) (
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] act
);

   if (ACC_W <= OUT_W) begin : g_width_chk
      $error("sample_acc_relu_sat: ACC_W must exceed OUT_W");
   end

   // Largest activation, held at accumulator width for a signed compare.
   localparam logic signed [ACC_W-1:0] MAXV =
      {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   function automatic logic [OUT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> SHIFT;
      if (s[ACC_W-1])
         return '0;
      else if (s > MAXV)
         return '1;
      else
         return s[OUT_W-1:0];
   endfunction

   always_comb begin
      act = relu_sat(signed'(acc));
   end

endmodule

// File: rtl/sample_acc_relu.sv
// Dot-product accumulator with ReLU activation.
// Collects N_TERMS signed products of one neuron on top of a bias, rescales
// by an arithmetic right shift, applies ReLU and saturates to OUT_W bits.
//   ap_clk, ap_rst      : clock, synchronous active-high reset
//   ap_start/idle/done  : block-level control (start sampled only in IDLE)
//   bias                : signed bias, captured on the start cycle
//   prod_t*             : valid/ready stream of signed products
//   res_t*              : valid/ready stream of unsigned activations
module sample_acc_relu #(
   parameter int PROD_W  = sample_acc_pkg::PROD_W,
   parameter int BIAS_W  = sample_acc_pkg::BIAS_W,
   parameter int ACC_W   = 24,
   parameter int N_TERMS = 16,
   parameter int SHIFT   = 4,
   parameter int OUT_W   = sample_acc_pkg::OUT_W
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_idle,
   output logic              ap_done,
   input  logic [BIAS_W-1:0] bias,
   input  logic [PROD_W-1:0] prod_tdata,
   input  logic              prod_tvalid,
   output logic              prod_tready,
   output logic [OUT_W-1:0]  res_tdata,
   output logic              res_tvalid,
   input  logic              res_tready
);

   import sample_acc_pkg::*;

   localparam int MIN_ACC_W = min_acc_w(PROD_W, BIAS_W, N_TERMS);
   localparam int CNT_W     = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

   if (N_TERMS < 1) begin : g_terms_chk
      $error("sample_acc_relu: N_TERMS must be at least 1");
   end
   if (ACC_W < MIN_ACC_W) begin : g_accw_chk
      $error("sample_acc_relu: ACC_W too small for PROD_W/BIAS_W/N_TERMS");
   end

   state_t                  state, state_nxt;
   logic                    tready_nxt;
   logic                    tvalid_nxt;
   logic                    load_bias;
   logic                    prod_hs;

   logic signed [ACC_W-1:0] acc_p0;
   logic [CNT_W-1:0]        cnt_p0;
   logic signed [ACC_W-1:0] bias_ext;
   logic signed [ACC_W-1:0] prod_ext;
   logic [OUT_W-1:0]        act_p1;

   assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
   assign prod_ext = {{(ACC_W-PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};

   // Next-state and block-control decode. prod_tready and res_tvalid are
   // registered, so their next values are decided here as well.
   always_comb begin
      state_nxt  = state;
      tready_nxt = prod_tready;
      tvalid_nxt = res_tvalid;
      load_bias  = 1'b0;
      prod_hs    = 1'b0;
      ap_idle    = 1'b0;
      ap_done    = 1'b0;
      case (state)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               load_bias  = 1'b1;
               tready_nxt = 1'b1;
               state_nxt  = ACC;
            end
         end
         ACC: begin
            if (prod_tvalid && prod_tready) begin
               prod_hs = 1'b1;
               if (cnt_p0 == LAST) begin
                  tready_nxt = 1'b0;
                  state_nxt  = ACT;
               end
            end
         end
         ACT: begin
            tvalid_nxt = 1'b1;
            state_nxt  = OUT;
         end
         OUT: begin
            if (res_tready) begin
               ap_done    = 1'b1;
               tvalid_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            tready_nxt = 1'b0;
            tvalid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state       <= IDLE;
         prod_tready <= 1'b0;
         res_tvalid  <= 1'b0;
      end else begin
         state       <= state_nxt;
         prod_tready <= tready_nxt;
         res_tvalid  <= tvalid_nxt;
      end
   end

   // Stage p0: bias load and product accumulation.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc_p0 <= '0;
         cnt_p0 <= '0;
      end else if (load_bias) begin
         acc_p0 <= bias_ext;
         cnt_p0 <= '0;
      end else if (prod_hs) begin
         acc_p0 <= acc_p0 + prod_ext;
         cnt_p0 <= cnt_p0 + 1'b1;
      end
   end

   sample_acc_relu_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_sat (
      .acc (acc_p0),
      .act (act_p1)
   );

   // Stage p1: activation captured in ACT, held until the next ACT.
   always_ff @(posedge ap_clk) begin
      if (ap_rst)
         res_tdata <= '0;
      else if (state == ACT)
         res_tdata <= act_p1;
   end

endmodule

// File: tb/tb_sample_acc_relu.sv
module tb_sample_acc_relu;

   logic              ap_clk;
   logic              ap_rst;
   logic              ap_start;
   logic              ap_idle;
   logic              ap_done;
   logic [12:0]       bias;
   logic [12:0]       prod_tdata;
   logic              prod_tvalid;
   logic              prod_tready;
   logic [7:0]        res_tdata;
   logic              res_tvalid;
   logic              res_tready;

   logic signed [23:0] sat_acc;
   logic [7:0]         sat_act;

   int total;
   int bad;
   int cyc;

   sample_acc_relu #(
      .PROD_W  (13),
      .BIAS_W  (13),
      .ACC_W   (24),
      .N_TERMS (4),
      .SHIFT   (4),
      .OUT_W   (8)
   ) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .ap_start    (ap_start),
      .ap_idle     (ap_idle),
      .ap_done     (ap_done),
      .bias        (bias),
      .prod_tdata  (prod_tdata),
      .prod_tvalid (prod_tvalid),
      .prod_tready (prod_tready),
      .res_tdata   (res_tdata),
      .res_tvalid  (res_tvalid),
      .res_tready  (res_tready)
   );

   sample_acc_relu_sat #(
      .ACC_W (24),
      .SHIFT (4),
      .OUT_W (8)
   ) u_sat_unit (
      .acc (sat_acc),
      .act (sat_act)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   task automatic tick();
      @(posedge ap_clk);
      #1;
      cyc++;
   endtask

   // Presents one product and waits (bounded) until it is handshaken.
   task automatic send_prod(input logic signed [12:0] d, output bit ok);
      int n;
      n = 0;
      prod_tdata  = d;
      prod_tvalid = 1'b1;
      while (!prod_tready && n < 50) begin
         tick();
         n++;
      end
      ok = prod_tready;
      tick();
      prod_tvalid = 1'b0;
   endtask

   task automatic wait_res(output bit ok);
      int n;
      n = 0;
      while (!res_tvalid && n < 50) begin
         tick();
         n++;
      end
      ok = res_tvalid;
   endtask

   // Full transaction from IDLE with immediate acceptance of the result.
   task automatic run_txn(input logic signed [12:0] b,
                          input logic signed [12:0] p0, input logic signed [12:0] p1,
                          input logic signed [12:0] p2, input logic signed [12:0] p3,
                          output logic [7:0] res, output bit ok);
      bit o;
      ok = 1'b1;
      bias = b;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      send_prod(p0, o); ok &= o;
      send_prod(p1, o); ok &= o;
      send_prod(p2, o); ok &= o;
      send_prod(p3, o); ok &= o;
      wait_res(o); ok &= o;
      res = res_tdata;
      res_tready = 1'b1;
      tick();
      res_tready = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      tick();
      tick();
      total++;
      if (prod_tready !== 1'b0 || res_tvalid !== 1'b0 || res_tdata !== 8'd0 ||
          ap_idle !== 1'b1 || ap_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_values tready=%b tvalid=%b tdata=%0d idle=%b done=%b want 0 0 0 1 0",
                  prod_tready, res_tvalid, res_tdata, ap_idle, ap_done);
      end
      ap_rst = 1'b0;
      tick();
   endtask

   task automatic test_sat_unit();
      logic signed [23:0] va [10] = '{24'sd80, -24'sd60, 24'sd20475, 24'sd4095, 24'sd4096,
                                      -24'sd1, 24'sd15, 24'sd16, 24'sh7FFFFF, 24'sh800000};
      logic [7:0]         ve [10] = '{8'd5, 8'd0, 8'd255, 8'd255, 8'd255,
                                      8'd0, 8'd0, 8'd1, 8'd255, 8'd0};
      for (int i = 0; i < 10; i++) begin
         sat_acc = va[i];
         #1;
         total++;
         if (sat_act !== ve[i]) begin
            bad++;
            $display("FAIL sat_unit[%0d] acc=%0d act=%0d want %0d", i, va[i], sat_act, ve[i]);
         end
      end
   endtask

   task automatic test_basic();
      bit ok;
      logic signed [12:0] p [4] = '{13'sd16, 13'sd32, -13'sd8, 13'sd40};
      bias = 13'sd0;
      ap_start = 1'b1;
      total++;
      if (ap_idle !== 1'b1) begin
         bad++;
         $display("FAIL basic_idle_before idle=%b want 1", ap_idle);
      end
      tick();
      ap_start = 1'b0;
      total++;
      if (ap_idle !== 1'b0 || prod_tready !== 1'b1) begin
         bad++;
         $display("FAIL basic_enter_acc idle=%b tready=%b want 0 1", ap_idle, prod_tready);
      end
      for (int i = 0; i < 4; i++) begin
         send_prod(p[i], ok);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL basic_handshake[%0d] tready=0 want 1 (timeout)", i);
         end
      end
      // one cycle after the last handshake: ACT, nothing visible yet
      total++;
      if (res_tvalid !== 1'b0 || prod_tready !== 1'b0 || ap_done !== 1'b0) begin
         bad++;
         $display("FAIL basic_act_cycle tvalid=%b tready=%b done=%b want 0 0 0",
                  res_tvalid, prod_tready, ap_done);
      end
      tick();
      total++;
      if (res_tvalid !== 1'b1 || res_tdata !== 8'd5) begin
         bad++;
         $display("FAIL basic_result tvalid=%b tdata=%0d want 1 5", res_tvalid, res_tdata);
      end
      res_tready = 1'b1;
      #1;
      total++;
      if (ap_done !== 1'b1) begin
         bad++;
         $display("FAIL basic_done_pulse done=%b want 1", ap_done);
      end
      tick();
      res_tready = 1'b0;
      #1;
      total++;
      if (ap_done !== 1'b0 || res_tvalid !== 1'b0 || ap_idle !== 1'b1 || res_tdata !== 8'd5) begin
         bad++;
         $display("FAIL basic_after_accept done=%b tvalid=%b idle=%b tdata=%0d want 0 0 1 5",
                  ap_done, res_tvalid, ap_idle, res_tdata);
      end
   endtask

   task automatic test_relu();
      bit ok;
      logic [7:0] r;
      run_txn(-13'sd100, 13'sd10, 13'sd10, 13'sd10, 13'sd10, r, ok);
      total++;
      if (!ok || r !== 8'd0) begin
         bad++;
         $display("FAIL relu result=%0d ok=%b want 0 ok=1", r, ok);
      end
   endtask

   task automatic test_saturate();
      bit ok;
      logic [7:0] r;
      run_txn(13'sd4095, 13'sd4095, 13'sd4095, 13'sd4095, 13'sd4095, r, ok);
      total++;
      if (!ok || r !== 8'd255) begin
         bad++;
         $display("FAIL saturate result=%0d ok=%b want 255 ok=1", r, ok);
      end
   endtask

   task automatic test_gaps();
      bit ok;
      logic signed [12:0] p [4] = '{13'sd16, 13'sd32, -13'sd8, 13'sd40};
      bias = 13'sd0;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_prod(p[i], ok);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL gaps_handshake[%0d] timeout tready=0 want 1", i);
         end
         if (i < 3) begin
            for (int g = 0; g < 3; g++) tick();
         end
      end
      wait_res(ok);
      for (int s = 0; s < 5; s++) begin
         total++;
         if (!ok || res_tvalid !== 1'b1 || res_tdata !== 8'd5 || ap_done !== 1'b0) begin
            bad++;
            $display("FAIL gaps_stall[%0d] tvalid=%b tdata=%0d done=%b want 1 5 0",
                     s, res_tvalid, res_tdata, ap_done);
         end
         tick();
      end
      res_tready = 1'b1;
      #1;
      total++;
      if (ap_done !== 1'b1 || res_tdata !== 8'd5) begin
         bad++;
         $display("FAIL gaps_accept done=%b tdata=%0d want 1 5", ap_done, res_tdata);
      end
      tick();
      res_tready = 1'b0;
      #1;
      total++;
      if (ap_done !== 1'b0 || res_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL gaps_after done=%b tvalid=%b want 0 0", ap_done, res_tvalid);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [7:0] r;
      bias = 13'sd0;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      send_prod(13'sd16, ok);
      send_prod(13'sd32, ok);
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      total++;
      if (prod_tready !== 1'b0 || ap_idle !== 1'b1 || res_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_acc tready=%b idle=%b tvalid=%b want 0 1 0",
                  prod_tready, ap_idle, res_tvalid);
      end
      run_txn(13'sd0, 13'sd16, 13'sd32, -13'sd8, 13'sd40, r, ok);
      total++;
      if (!ok || r !== 8'd5) begin
         bad++;
         $display("FAIL reset_mid_rerun result=%0d ok=%b want 5 ok=1", r, ok);
      end
      // reset while a result is pending
      bias = 13'sd0;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      send_prod(13'sd16, ok);
      send_prod(13'sd32, ok);
      send_prod(-13'sd8, ok);
      send_prod(13'sd40, ok);
      wait_res(ok);
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      total++;
      if (!ok || res_tvalid !== 1'b0 || res_tdata !== 8'd0 || ap_idle !== 1'b1) begin
         bad++;
         $display("FAIL reset_pending ok=%b tvalid=%b tdata=%0d idle=%b want 1 0 0 1",
                  ok, res_tvalid, res_tdata, ap_idle);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int c0;
      logic signed [12:0] bv [3] = '{13'sd0, -13'sd100, 13'sd4095};
      logic signed [12:0] pv [3][4] = '{'{13'sd16, 13'sd32, -13'sd8, 13'sd40},
                                        '{13'sd10, 13'sd10, 13'sd10, 13'sd10},
                                        '{13'sd4095, 13'sd4095, 13'sd4095, 13'sd4095}};
      logic [7:0] ev [3] = '{8'd5, 8'd0, 8'd255};
      ap_start = 1'b1;
      for (int r = 0; r < 3; r++) begin
         bias = bv[r];
         c0 = cyc;
         total++;
         if (ap_idle !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle[%0d] idle=%b want 1", r, ap_idle);
         end
         tick();
         total++;
         if (ap_idle !== 1'b0) begin
            bad++;
            $display("FAIL b2b_one_idle[%0d] idle=%b want 0", r, ap_idle);
         end
         for (int i = 0; i < 4; i++) send_prod(pv[r][i], ok);
         wait_res(ok);
         total++;
         if (!ok || res_tdata !== ev[r]) begin
            bad++;
            $display("FAIL b2b_result[%0d] tdata=%0d ok=%b want %0d ok=1", r, res_tdata, ok, ev[r]);
         end
         res_tready = 1'b1;
         tick();
         res_tready = 1'b0;
         total++;
         if (cyc - c0 != 7) begin
            bad++;
            $display("FAIL b2b_period[%0d] cycles=%0d want 7", r, cyc - c0);
         end
      end
      ap_start = 1'b0;
      tick();
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      ap_rst = 1'b1;
      ap_start = 1'b0;
      bias = '0;
      prod_tdata = '0;
      prod_tvalid = 1'b0;
      res_tready = 1'b0;
      sat_acc = '0;
      test_reset();
      test_sat_unit();
      test_basic();
      test_relu();
      test_saturate();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout sim time exceeded want finish");
      $fatal(1, "timeout");
   end

endmodule
